// File: rtl/mouse_pkg.sv
// mouse_pkg: constants shared by the mouse position tracker files.
//   - PS/2 status byte bit positions (overflow, sign, button field)
//   - DELTA_W: width of the raw signed movement delta
//   - ACCEL_THRESH: magnitude at which the optional acceleration doubles a delta
package mouse_pkg;

  localparam int XOVF         = 6;
  localparam int YOVF         = 7;
  localparam int XSIGN        = 4;
  localparam int YSIGN        = 5;
  localparam int BTN_LSB      = 0;
  localparam int BTN_W        = 3;
  localparam int DELTA_W      = 9;
  localparam int ACCEL_THRESH = 16;

endpackage

// File: rtl/mouse_axis_accum.sv
// mouse_axis_accum: one accumulating axis (X, Y or scroll).
// Holds the absolute position register and adds a signed delta to it,
// then either clamps the sum to 0..LIMIT-1 or wraps it modulo LIMIT.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset, position -> LIMIT/2
//   recenter  in   position -> LIMIT/2 on the next edge (beats en)
//   en        in   commit delta this cycle
//   delta     in   signed delta, COORD_W+5 bits
//   pos       out  current position, COORD_W bits
module mouse_axis_accum
  import mouse_pkg::*;
#(
  parameter int COORD_W  = 10,
  parameter int LIMIT    = 640,
  parameter int WRAP     = 0,
  parameter int MAX_STEP = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      recenter,
  input  logic                      en,
  input  logic signed [COORD_W+4:0] delta,
  output logic        [COORD_W-1:0] pos
);

  localparam int SW = COORD_W + 5;
  localparam logic signed [SW-1:0]  LIM_S     = SW'(LIMIT);
  localparam logic signed [SW-1:0]  MAX_S     = SW'(LIMIT - 1);
  localparam logic [COORD_W-1:0]    CLAMP_MAX = COORD_W'(LIMIT - 1);
  localparam logic [COORD_W-1:0]    CENTRE    = COORD_W'(LIMIT / 2);

  if (LIMIT < 2 || LIMIT > (1 << COORD_W)) begin : g_bad_limit
    $error("mouse_axis_accum: LIMIT does not fit in COORD_W bits");
  end
  // A wrapped axis corrects the sum once; that is only exact while
  // one step can never exceed the full range.
  if (WRAP != 0 && LIMIT < MAX_STEP) begin : g_bad_wrap
    $error("mouse_axis_accum: wrapped axis needs LIMIT >= MAX_STEP");
  end

  function automatic logic [COORD_W-1:0] clamp_fn(input logic signed [SW-1:0] s);
    logic [COORD_W-1:0] r;
    if (s[SW-1])
      r = '0;
    else if (s > MAX_S)
      r = CLAMP_MAX;
    else
      r = COORD_W'(s);
    return r;
  endfunction

  function automatic logic [COORD_W-1:0] wrap_fn(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] t;
    if (s[SW-1])
      t = s + LIM_S;
    else if (s >= LIM_S)
      t = s - LIM_S;
    else
      t = s;
    return COORD_W'(t);
  endfunction

  logic signed [SW-1:0]      sum;
  logic        [COORD_W-1:0] pos_next;

  // Stage 2: position + delta, then clamp or wrap
  assign sum = $signed({5'b0, pos}) + delta;

  always_comb begin
    pos_next = pos;
    if (WRAP != 0)
      pos_next = wrap_fn(sum);
    else
      pos_next = clamp_fn(sum);
  end

  always_ff @(posedge clk) begin
    if (rst || recenter)
      pos <= CENTRE;
    else if (en)
      pos <= pos_next;
  end

endmodule

// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker: absolute pointer/scroll tracking from decoded
// 4-byte PS/2 mouse packets, two-stage pipeline, one packet per cycle.
// Stage 1 builds signed, scaled deltas; stage 2 accumulates them into the
// X/Y/scroll position registers and latches buttons.
// Optional build macro: MOUSE_ACCEL_EN (doubles deltas of magnitude >= 16).
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   PKT_VALID         packet strobe; PKT_STATUS/DX/DY/DSCROLL valid this cycle
//   RECENTER          strobe; positions to centre, in-flight packets dropped
//   POS_X, POS_Y      absolute position, COORD_W bits
//   SCROLL            absolute scroll value, 8 bits
//   BUTTONS           latched buttons M/R/L
//   BTN_PRESS         press pulses, only with UPDATED
//   UPDATED           outputs reflect a new packet this cycle
module mouse_position_tracker
  import mouse_pkg::*;
#(
  parameter int COORD_W      = 10,
  parameter int LIMIT_X      = 640,
  parameter int LIMIT_Y      = 480,
  parameter int LIMIT_SCROLL = 256,
  parameter int WRAP_X       = 0,
  parameter int WRAP_Y       = 0,
  parameter int DELTA_SHIFT  = 0,
  parameter int Y_INVERT     = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               PKT_VALID,
  input  logic [7:0]         PKT_STATUS,
  input  logic [7:0]         PKT_DX,
  input  logic [7:0]         PKT_DY,
  input  logic [7:0]         PKT_DSCROLL,
  input  logic               RECENTER,
  output logic [COORD_W-1:0] POS_X,
  output logic [COORD_W-1:0] POS_Y,
  output logic [7:0]         SCROLL,
  output logic [2:0]         BUTTONS,
  output logic [2:0]         BTN_PRESS,
  output logic               UPDATED
);

  localparam int SW        = COORD_W + 5;
  localparam int SCROLL_W  = 8;
  localparam int SCROLL_SW = SCROLL_W + 5;
`ifdef MOUSE_ACCEL_EN
  localparam int MAX_STEP = 512 << DELTA_SHIFT;
  localparam logic signed [DELTA_W:0] ACC_POS = (DELTA_W + 1)'(ACCEL_THRESH);
  localparam logic signed [DELTA_W:0] ACC_NEG = -ACC_POS;
`else
  localparam int MAX_STEP = 256 << DELTA_SHIFT;
`endif

  if (COORD_W < 8 || COORD_W > 12) begin : g_bad_coord_w
    $error("mouse_position_tracker: COORD_W must be 8..12");
  end
  if (DELTA_SHIFT < 0 || DELTA_SHIFT > 3) begin : g_bad_shift
    $error("mouse_position_tracker: DELTA_SHIFT must be 0..3");
  end
  if (LIMIT_SCROLL > 256) begin : g_bad_scroll
    $error("mouse_position_tracker: LIMIT_SCROLL must be <= 256");
  end

  // Overflowed PS/2 deltas saturate to the extreme of their sign.
  function automatic logic signed [DELTA_W-1:0] sat_delta(input logic ovf, input logic sgn,
                                                          input logic [7:0] mag);
    logic signed [DELTA_W-1:0] r;
    if (ovf)
      r = sgn ? 9'sh100 : 9'sh0FF;
    else
      r = {sgn, mag};
    return r;
  endfunction

  function automatic logic signed [SW-1:0] scale_delta(input logic signed [DELTA_W:0] d);
    logic signed [SW-1:0] e;
    e = {{(SW - DELTA_W - 1){d[DELTA_W]}}, d};
    e = e <<< DELTA_SHIFT;
`ifdef MOUSE_ACCEL_EN
    if (d >= ACC_POS || d <= ACC_NEG)
      e = e <<< 1;
`endif
    return e;
  endfunction

  logic signed [DELTA_W-1:0] dx9, dy9;
  logic signed [DELTA_W:0]   dy10;
  logic signed [SW-1:0]      dx_s, dy_s;
  logic signed [SCROLL_SW-1:0] ds_s;

  logic                        vld_p1;
  logic signed [SW-1:0]        dx_p1, dy_p1;
  logic signed [SCROLL_SW-1:0] ds_p1;
  logic [BTN_W-1:0]            btn_p1;
  logic                        commit_p1;

  logic                        vld_p2;
  logic [BTN_W-1:0]            buttons_p2;
  logic [BTN_W-1:0]            btn_press_p2;

  logic                        unused_bits;
  assign unused_bits = ^{PKT_STATUS[3], PKT_DSCROLL[7:4]};

  // Stage 1: signed deltas from the raw packet
  always_comb begin
    dx9  = sat_delta(PKT_STATUS[XOVF], PKT_STATUS[XSIGN], PKT_DX);
    dy9  = sat_delta(PKT_STATUS[YOVF], PKT_STATUS[YSIGN], PKT_DY);
    // 10 bits so that -(-256) = +256 survives the negation
    dy10 = {dy9[DELTA_W-1], dy9};
    if (Y_INVERT != 0)
      dy10 = -dy10;
    dx_s = scale_delta({dx9[DELTA_W-1], dx9});
    dy_s = scale_delta(dy10);
    ds_s = {{(SCROLL_SW - 4){PKT_DSCROLL[3]}}, PKT_DSCROLL[3:0]};
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= PKT_VALID & ~RECENTER;
  end

  always_ff @(posedge CLK) begin
    if (PKT_VALID) begin
      dx_p1  <= dx_s;
      dy_p1  <= dy_s;
      ds_p1  <= ds_s;
      btn_p1 <= PKT_STATUS[BTN_LSB +: BTN_W];
    end
  end

  // Stage 2: accumulate and latch buttons
  assign commit_p1 = vld_p1 & ~RECENTER;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p2       <= 1'b0;
      buttons_p2   <= '0;
      btn_press_p2 <= '0;
    end else begin
      vld_p2       <= commit_p1;
      btn_press_p2 <= commit_p1 ? (btn_p1 & ~buttons_p2) : '0;
      if (commit_p1)
        buttons_p2 <= btn_p1;
    end
  end

  mouse_axis_accum #(
    .COORD_W (COORD_W),
    .LIMIT   (LIMIT_X),
    .WRAP    (WRAP_X),
    .MAX_STEP(MAX_STEP)
  ) u_axis_x (
    .clk     (CLK),
    .rst     (RESET),
    .recenter(RECENTER),
    .en      (vld_p1),
    .delta   (dx_p1),
    .pos     (POS_X)
  );

  mouse_axis_accum #(
    .COORD_W (COORD_W),
    .LIMIT   (LIMIT_Y),
    .WRAP    (WRAP_Y),
    .MAX_STEP(MAX_STEP)
  ) u_axis_y (
    .clk     (CLK),
    .rst     (RESET),
    .recenter(RECENTER),
    .en      (vld_p1),
    .delta   (dy_p1),
    .pos     (POS_Y)
  );

  mouse_axis_accum #(
    .COORD_W (SCROLL_W),
    .LIMIT   (LIMIT_SCROLL),
    .WRAP    (1),
    .MAX_STEP(8)
  ) u_axis_scroll (
    .clk     (CLK),
    .rst     (RESET),
    .recenter(RECENTER),
    .en      (vld_p1),
    .delta   (ds_p1),
    .pos     (SCROLL)
  );

  assign BUTTONS   = buttons_p2;
  assign BTN_PRESS = btn_press_p2;
  assign UPDATED   = vld_p2;

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Bench for mouse_position_tracker: two instances (clamped X and wrapped X)
// share stimulus; a reference model pushes expected results into a queue
// at drive time and a negedge monitor pops and compares them on UPDATED.
module tb_mouse_position_tracker;

  localparam int LX = 640;
  localparam int LY = 480;
  localparam int LS = 256;
  localparam int DSH = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [7:0] pkt_status, pkt_dx, pkt_dy, pkt_dscroll;
  logic       recenter;

  logic [9:0] a_pos_x, a_pos_y, b_pos_x, b_pos_y;
  logic [7:0] a_scroll, b_scroll;
  logic [2:0] a_buttons, b_buttons, a_press, b_press;
  logic       a_upd, b_upd;

  always #5 clk = ~clk;

  mouse_position_tracker u_dut_a (
    .CLK(clk), .RESET(rst), .PKT_VALID(pkt_valid), .PKT_STATUS(pkt_status),
    .PKT_DX(pkt_dx), .PKT_DY(pkt_dy), .PKT_DSCROLL(pkt_dscroll), .RECENTER(recenter),
    .POS_X(a_pos_x), .POS_Y(a_pos_y), .SCROLL(a_scroll), .BUTTONS(a_buttons),
    .BTN_PRESS(a_press), .UPDATED(a_upd)
  );

  mouse_position_tracker #(.WRAP_X(1)) u_dut_b (
    .CLK(clk), .RESET(rst), .PKT_VALID(pkt_valid), .PKT_STATUS(pkt_status),
    .PKT_DX(pkt_dx), .PKT_DY(pkt_dy), .PKT_DSCROLL(pkt_dscroll), .RECENTER(recenter),
    .POS_X(b_pos_x), .POS_Y(b_pos_y), .SCROLL(b_scroll), .BUTTONS(b_buttons),
    .BTN_PRESS(b_press), .UPDATED(b_upd)
  );

  typedef struct {
    int         due;
    int         xa, xb, y, s;
    logic [2:0] btn, press, prev_btn;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;

  int         xa_m, xb_m, y_m, s_m;
  logic [2:0] btn_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int raw_delta(input bit ovf, input bit sgn, input logic [7:0] mag);
    if (ovf) return sgn ? -256 : 255;
    return sgn ? int'(mag) - 256 : int'(mag);
  endfunction

  function automatic int scale(input int d);
    int r;
    r = d * (1 << DSH);
`ifdef MOUSE_ACCEL_EN
    if (d >= 16 || d <= -16) r = r * 2;
`endif
    return r;
  endfunction

  function automatic int clampm(input int v, input int lim);
    if (v < 0) return 0;
    if (v > lim - 1) return lim - 1;
    return v;
  endfunction

  function automatic int wrapm(input int v, input int lim);
    return ((v % lim) + lim) % lim;
  endfunction

  // One clock cycle of stimulus; the model is updated at drive time.
  task automatic step(input bit v, input logic [7:0] st, input logic [7:0] dx,
                      input logic [7:0] dy, input logic [7:0] ds,
                      input bit rc, input bit rs);
    exp_t e;
    int dxv, dyv, dsv;
    pkt_valid = v; pkt_status = st; pkt_dx = dx; pkt_dy = dy; pkt_dscroll = ds;
    recenter = rc; rst = rs;
    if (rs || rc) begin
      while (q.size() > 0 && q[q.size()-1].due > cyc) begin
        btn_m = q[q.size()-1].prev_btn;
        void'(q.pop_back());
      end
      xa_m = LX / 2; xb_m = LX / 2; y_m = LY / 2; s_m = LS / 2;
      if (rs) btn_m = 3'b000;
    end else if (v) begin
      dxv = scale(raw_delta(st[6], st[4], dx));
      dyv = scale(-raw_delta(st[7], st[5], dy));
      dsv = ds[3] ? int'(ds[3:0]) - 16 : int'(ds[3:0]);
      xa_m = clampm(xa_m + dxv, LX);
      xb_m = wrapm(xb_m + dxv, LX);
      y_m  = clampm(y_m + dyv, LY);
      s_m  = wrapm(s_m + dsv, LS);
      e.due = cyc + 2;
      e.xa = xa_m; e.xb = xb_m; e.y = y_m; e.s = s_m;
      e.prev_btn = btn_m;
      e.press = st[2:0] & ~btn_m;
      e.btn = st[2:0];
      btn_m = st[2:0];
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy,
                     input logic [7:0] ds);
    step(1'b1, st, dx, dy, ds, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_centre(input string tag);
    check_val({tag, "_xa"}, a_pos_x, LX / 2);
    check_val({tag, "_xb"}, b_pos_x, LX / 2);
    check_val({tag, "_y"}, a_pos_y, LY / 2);
    check_val({tag, "_upd"}, a_upd, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_val("upd_b_vs_a", b_upd, a_upd);
      if (a_upd === 1'b1) begin
        if (q.size() == 0) begin
          check_val("unexpected_upd", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check_val("latency", cyc, mon_e.due);
          check_val("pos_x_clamp", a_pos_x, mon_e.xa);
          check_val("pos_x_wrap", b_pos_x, mon_e.xb);
          check_val("pos_y", a_pos_y, mon_e.y);
          check_val("scroll", a_scroll, mon_e.s);
          check_val("buttons", a_buttons, mon_e.btn);
          check_val("btn_press", a_press, mon_e.press);
        end
      end else begin
        check_val("btn_press_idle", a_press, 0);
        if (q.size() > 0 && q[0].due <= cyc) begin
          check_val("missing_upd", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    btn_m = 3'b000;
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    mon_en = 1'b1;
    idle(3);
    check_centre("reset");
    check_val("reset_scroll", a_scroll, 128);
    check_val("reset_buttons", a_buttons, 0);

    // basic move: dx=+16, dy=+16 inverted
    pkt(8'h00, 8'h10, 8'h10, 8'h00);
    idle(3);

    // X overflow negative from X=100: clamp -> 0, wrap -> 484
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    check_centre("recenter1");
    pkt(8'h10, 8'h24, 8'h00, 8'h00);
    pkt(8'h50, 8'h00, 8'h00, 8'h00);
    idle(3);

    // back-to-back +5 packets with left button press/hold/release
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    pkt(8'h01, 8'h05, 8'h00, 8'h00);
    pkt(8'h01, 8'h05, 8'h00, 8'h00);
    pkt(8'h00, 8'h05, 8'h00, 8'h00);
    idle(3);

    // packet in flight plus a packet coincident with RECENTER: both dropped
    pkt(8'h03, 8'h40, 8'h20, 8'h01);
    step(1'b1, 8'h04, 8'h40, 8'h20, 8'h01, 1'b1, 1'b0);
    check_centre("recenter_drop");
    idle(3);
    check_centre("recenter_hold");

    // scroll down to 0, then -1 wraps to 255
    for (int i = 0; i < 16; i++) pkt(8'h00, 8'h00, 8'h00, 8'h08);
    pkt(8'h00, 8'h00, 8'h00, 8'h0F);
    idle(3);
    check_val("scroll_wrap", a_scroll, 255);

    // reset with a packet in flight discards it
    pkt(8'h07, 8'h30, 8'h30, 8'h03);
    step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    check_centre("reset_mid");
    check_val("reset_mid_btn", a_buttons, 0);
    idle(3);

    // random traffic including overflow, sign, buttons and recenter
    for (int i = 0; i < 120; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom), $urandom_range(0, 15) == 0, 1'b0);
    end
    idle(4);
    check_val("drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
